// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared graphics definitions: visible screen size and sprite motion state encoding.
package sprite_motion_ctrl_pkg;

  localparam logic [9:0] GFX_SCREEN_W = 10'd640;
  localparam logic [8:0] GFX_SCREEN_H = 9'd480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } motion_state_t;

  // -8 has no positive counterpart in 4 bits, so it bounces back as +7.
  function automatic logic [3:0] vel_negate(input logic [3:0] v);
    return (v == 4'b1000) ? 4'b0111 : (~v + 4'd1);
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One axis of sprite motion: add signed velocity, clamp to [0, LIMIT], bounce velocity on clamp.
module sprite_axis_step
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int             W     = 10,
  parameter logic [W-1:0]   LIMIT = '1
) (
  input  logic [W-1:0] pos,
  input  logic [3:0]   vel,
  output logic [W-1:0] next_pos,
  output logic [3:0]   next_vel
);

  logic signed [W:0] sum;

  always_comb begin
    sum      = $signed({1'b0, pos}) + $signed({{(W-3){vel[3]}}, vel});
    next_pos = sum[W-1:0];
    next_vel = vel;
    if (sum[W]) begin
      next_pos = '0;
      next_vel = vel_negate(vel);
    end else if (sum > $signed({1'b0, LIMIT})) begin
      next_pos = LIMIT;
      next_vel = vel_negate(vel);
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: frame-synchronous bouncing motion with a one-entry position-load slot.
//   state | meaning
//   IDLE  | after reset, sprite not drawn, waiting for first frame with iGo
//   RUN   | drawn and moving by latched velocity each frame
//   HOLD  | drawn but frozen until a frame with iGo
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter logic [9:0] INIT_X   = 10'd200,
  parameter logic [8:0] INIT_Y   = 9'd100,
  parameter logic [9:0] SPRITE_W = 10'd110,
  parameter logic [8:0] SPRITE_H = 9'd200,
  parameter logic [9:0] SCREEN_W = GFX_SCREEN_W,
  parameter logic [8:0] SCREEN_H = GFX_SCREEN_H
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iFrameStart,
  input  logic       iGo,
  input  logic [3:0] iVel_X,
  input  logic [3:0] iVel_Y,
  input  logic       iLoad_valid,
  input  logic [9:0] iLoad_X,
  input  logic [8:0] iLoad_Y,
  output logic       oLoad_ready,
  output logic [9:0] oTopLeft_X,
  output logic [8:0] oTopLeft_Y,
  output logic       oEnable,
  output logic       oMotion_en
);

  localparam logic [9:0] LIMIT_X = SCREEN_W - SPRITE_W;
  localparam logic [8:0] LIMIT_Y = SCREEN_H - SPRITE_H;

  motion_state_t state, state_nxt;

  logic [9:0] pos_x, pend_x, step_pos_x;
  logic [8:0] pos_y, pend_y, step_pos_y;
  logic [3:0] vel_x, vel_y, vel_sel_x, vel_sel_y, step_vel_x, step_vel_y;
  logic       pend_full, load_acc, step_en;

  assign load_acc = iLoad_valid && !pend_full;
  // Entering RUN moves on the same frame using the freshly presented velocity.
  assign step_en   = (state == RUN) || (iGo && (state == IDLE || state == HOLD));
  assign vel_sel_x = (state == RUN) ? vel_x : iVel_X;
  assign vel_sel_y = (state == RUN) ? vel_y : iVel_Y;

  sprite_axis_step #(.W(10), .LIMIT(LIMIT_X)) u_step_x (
    .pos      (pos_x),
    .vel      (vel_sel_x),
    .next_pos (step_pos_x),
    .next_vel (step_vel_x)
  );

  sprite_axis_step #(.W(9), .LIMIT(LIMIT_Y)) u_step_y (
    .pos      (pos_y),
    .vel      (vel_sel_y),
    .next_pos (step_pos_y),
    .next_vel (step_vel_y)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (iFrameStart) begin
      case (state)
        IDLE:    if (iGo)  state_nxt = RUN;
        RUN:     if (!iGo) state_nxt = HOLD;
        HOLD:    if (iGo)  state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x     <= INIT_X;
      pos_y     <= INIT_Y;
      vel_x     <= '0;
      vel_y     <= '0;
      pend_full <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
    end else begin
      if (iFrameStart) begin
        if (pend_full) begin
          pos_x     <= pend_x;
          pos_y     <= pend_y;
          pend_full <= 1'b0;
        end else if (step_en) begin
          pos_x <= step_pos_x;
          pos_y <= step_pos_y;
        end
        if (step_en) begin
          vel_x <= pend_full ? vel_sel_x : step_vel_x;
          vel_y <= pend_full ? vel_sel_y : step_vel_y;
        end
      end
      // A load coincident with a frame start lands after that frame's update.
      if (load_acc) begin
        pend_full <= 1'b1;
        pend_x    <= (iLoad_X > LIMIT_X) ? LIMIT_X : iLoad_X;
        pend_y    <= (iLoad_Y > LIMIT_Y) ? LIMIT_Y : iLoad_Y;
      end
    end
  end

  assign oLoad_ready = !pend_full;
  assign oTopLeft_X  = pos_x;
  assign oTopLeft_Y  = pos_y;
  assign oEnable     = (state != IDLE);
  assign oMotion_en  = (state == RUN) && ((vel_x != 4'd0) || (vel_y != 4'd0));

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: motion, bounces, load clamping/timing, hold and reset.
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iFrameStart = 1'b0;
  logic       iGo = 1'b0;
  logic [3:0] iVel_X = 4'd0;
  logic [3:0] iVel_Y = 4'd0;
  logic       iLoad_valid = 1'b0;
  logic [9:0] iLoad_X = 10'd0;
  logic [8:0] iLoad_Y = 9'd0;
  logic       oLoad_ready;
  logic [9:0] oTopLeft_X;
  logic [8:0] oTopLeft_Y;
  logic       oEnable;
  logic       oMotion_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .iFrameStart (iFrameStart),
    .iGo         (iGo),
    .iVel_X      (iVel_X),
    .iVel_Y      (iVel_Y),
    .iLoad_valid (iLoad_valid),
    .iLoad_X     (iLoad_X),
    .iLoad_Y     (iLoad_Y),
    .oLoad_ready (oLoad_ready),
    .oTopLeft_X  (oTopLeft_X),
    .oTopLeft_Y  (oTopLeft_Y),
    .oEnable     (oEnable),
    .oMotion_en  (oMotion_en)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic frame(input logic go);
    @(negedge clk);
    iGo = go;
    iFrameStart = 1'b1;
    @(negedge clk);
    iFrameStart = 1'b0;
  endtask

  task automatic load(input logic [9:0] x, input logic [8:0] y);
    @(negedge clk);
    iLoad_valid = 1'b1;
    iLoad_X = x;
    iLoad_Y = y;
    @(negedge clk);
    iLoad_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (oTopLeft_X !== 10'd200) begin bad++; $display("FAIL reset_x got=%0d exp=200", oTopLeft_X); end
    total++; if (oTopLeft_Y !== 9'd100) begin bad++; $display("FAIL reset_y got=%0d exp=100", oTopLeft_Y); end
    total++; if ({oLoad_ready, oEnable, oMotion_en} !== 3'b100) begin bad++; $display("FAIL reset_flags got=%b exp=100", {oLoad_ready, oEnable, oMotion_en}); end
  endtask

  task automatic test_start_motion();
    do_reset();
    iVel_X = 4'd3; iVel_Y = 4'd0; iGo = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (oTopLeft_X !== 10'd200 || oEnable !== 1'b0) begin bad++; $display("FAIL no_frame_hold got x=%0d en=%b exp x=200 en=0", oTopLeft_X, oEnable); end
    frame(1'b1);
    total++; if (oTopLeft_X !== 10'd203) begin bad++; $display("FAIL start_x got=%0d exp=203", oTopLeft_X); end
    total++; if ({oEnable, oMotion_en} !== 2'b11) begin bad++; $display("FAIL start_flags got=%b exp=11", {oEnable, oMotion_en}); end
  endtask

  task automatic test_right_bounce();
    do_reset();
    load(10'd528, 9'd100);
    frame(1'b0);
    total++; if (oTopLeft_X !== 10'd528) begin bad++; $display("FAIL idle_load_x got=%0d exp=528", oTopLeft_X); end
    iVel_X = 4'd5; iVel_Y = 4'd0;
    frame(1'b1);
    total++; if (oTopLeft_X !== 10'd530) begin bad++; $display("FAIL right_clamp got=%0d exp=530", oTopLeft_X); end
    frame(1'b1);
    total++; if (oTopLeft_X !== 10'd525) begin bad++; $display("FAIL right_bounce got=%0d exp=525", oTopLeft_X); end
  endtask

  task automatic test_top_bounce();
    do_reset();
    load(10'd200, 9'd2);
    frame(1'b0);
    iVel_X = 4'd0; iVel_Y = 4'b1000;
    frame(1'b1);
    total++; if (oTopLeft_Y !== 9'd0 || oTopLeft_X !== 10'd200) begin bad++; $display("FAIL top_clamp got=(%0d,%0d) exp=(200,0)", oTopLeft_X, oTopLeft_Y); end
    frame(1'b1);
    total++; if (oTopLeft_Y !== 9'd7) begin bad++; $display("FAIL neg8_sat got=%0d exp=7", oTopLeft_Y); end
    total++; if (oMotion_en !== 1'b1) begin bad++; $display("FAIL top_motion_en got=%b exp=1", oMotion_en); end
  endtask

  task automatic test_load_clamp();
    do_reset();
    iVel_X = 4'd0; iVel_Y = 4'd0;
    load(10'd700, 9'd470);
    total++; if (oLoad_ready !== 1'b0) begin bad++; $display("FAIL load_busy got=%b exp=0", oLoad_ready); end
    total++; if (oTopLeft_X !== 10'd200) begin bad++; $display("FAIL load_deferred got=%0d exp=200", oTopLeft_X); end
    frame(1'b1);
    total++; if (oTopLeft_X !== 10'd530 || oTopLeft_Y !== 9'd280) begin bad++; $display("FAIL load_clamp got=(%0d,%0d) exp=(530,280)", oTopLeft_X, oTopLeft_Y); end
    total++; if ({oLoad_ready, oEnable, oMotion_en} !== 3'b110) begin bad++; $display("FAIL load_flags got=%b exp=110", {oLoad_ready, oEnable, oMotion_en}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    iVel_X = 4'd3; iVel_Y = 4'd0;
    frame(1'b1);
    @(negedge clk);
    iLoad_valid = 1'b1; iLoad_X = 10'd100; iLoad_Y = 9'd50;
    iFrameStart = 1'b1; iGo = 1'b1;
    @(negedge clk);
    iLoad_valid = 1'b0; iFrameStart = 1'b0;
    total++; if (oTopLeft_X !== 10'd206 || oLoad_ready !== 1'b0) begin bad++; $display("FAIL coincident got x=%0d rdy=%b exp x=206 rdy=0", oTopLeft_X, oLoad_ready); end
    frame(1'b1);
    total++; if (oTopLeft_X !== 10'd100 || oTopLeft_Y !== 9'd50) begin bad++; $display("FAIL coincident_apply got=(%0d,%0d) exp=(100,50)", oTopLeft_X, oTopLeft_Y); end
    frame(1'b1);
    total++; if (oTopLeft_X !== 10'd103) begin bad++; $display("FAIL after_load_move got=%0d exp=103", oTopLeft_X); end
  endtask

  task automatic test_hold();
    frame(1'b0);
    load(10'd300, 9'd60);
    frame(1'b0);
    total++; if (oTopLeft_X !== 10'd300 || oTopLeft_Y !== 9'd60) begin bad++; $display("FAIL hold_load got=(%0d,%0d) exp=(300,60)", oTopLeft_X, oTopLeft_Y); end
    total++; if ({oEnable, oMotion_en} !== 2'b10) begin bad++; $display("FAIL hold_flags got=%b exp=10", {oEnable, oMotion_en}); end
    frame(1'b0);
    total++; if (oTopLeft_X !== 10'd300 || oTopLeft_Y !== 9'd60) begin bad++; $display("FAIL hold_frozen got=(%0d,%0d) exp=(300,60)", oTopLeft_X, oTopLeft_Y); end
    iVel_X = 4'b1110; iVel_Y = 4'd1;
    frame(1'b1);
    total++; if (oTopLeft_X !== 10'd298 || oTopLeft_Y !== 9'd61) begin bad++; $display("FAIL resume got=(%0d,%0d) exp=(298,61)", oTopLeft_X, oTopLeft_Y); end
    iVel_X = 4'd7; iVel_Y = 4'd7;
    frame(1'b1);
    total++; if (oTopLeft_X !== 10'd296 || oTopLeft_Y !== 9'd62) begin bad++; $display("FAIL vel_latched got=(%0d,%0d) exp=(296,62)", oTopLeft_X, oTopLeft_Y); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    iVel_X = 4'd1; iVel_Y = 4'd1;
    frame(1'b1);
    total++; if (oTopLeft_X !== 10'd201 || oTopLeft_Y !== 9'd101) begin bad++; $display("FAIL pre_reset got=(%0d,%0d) exp=(201,101)", oTopLeft_X, oTopLeft_Y); end
    load(10'd400, 9'd200);
    do_reset();
    total++; if (oTopLeft_X !== 10'd200 || oTopLeft_Y !== 9'd100) begin bad++; $display("FAIL reset_pos got=(%0d,%0d) exp=(200,100)", oTopLeft_X, oTopLeft_Y); end
    total++; if ({oLoad_ready, oEnable, oMotion_en} !== 3'b100) begin bad++; $display("FAIL reset_pend_flags got=%b exp=100", {oLoad_ready, oEnable, oMotion_en}); end
    frame(1'b0);
    total++; if (oTopLeft_X !== 10'd200 || oTopLeft_Y !== 9'd100) begin bad++; $display("FAIL load_discarded got=(%0d,%0d) exp=(200,100)", oTopLeft_X, oTopLeft_Y); end
  endtask

  initial begin
    test_reset();
    test_start_motion();
    test_right_bounce();
    test_top_bounce();
    test_load_clamp();
    test_back_to_back();
    test_hold();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
